cpu_decode_stage: RTL and testbench
===================================

Name: cpu_decode_stage

Overview:
- Consumer end of the fetch→decode interface. Accepts next_PC, valid_instr and the 32-bit instr from fetch.
- Cracks R/M/B formats, reads a 32x32 register file and detects load-use hazards.
- Registers a decoded bundle into the decode/execute pipeline register. Also hosts the register file write port driven by writeback.

Parameters:
- VADDR_W, 32, virtual PC width.
- DATA_W, 32, register/operand width.
- NREGS, 32, register count; addressed by 5-bit fields.

Ports:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous reset, active-low
- valid_instr  in  1  fetch bundle valid
- next_PC  in  VADDR_W  PC associated with instr
- instr  in  32  opcode[31:25], dst/offset_high[24:20], src1[19:15], src2[14:10], low[9:0]
- fetch_stall  out  1  fetch must hold its bundle this cycle
- ex_stall  in  1  execute cannot accept; hold EX register
- flush  in  1  redirect from execute; kill decode and EX bundle
- wb_en  in  1  register write enable
- wb_addr  in  5  write index
- wb_data  in  DATA_W  write data
- ex_valid  out  1  EX bundle valid
- ex_pc  out  VADDR_W  bundle PC
- ex_op  out  7  opcode
- ex_dst  out  5  destination index
- ex_rs1  out  DATA_W  src1 value
- ex_rs2  out  DATA_W  src2 value
- ex_imm  out  DATA_W  sign-extended immediate
- ex_rf_we  out  1  instruction writes a register
- ex_illegal  out  1  unknown opcode (feature only)

Behaviour:
- Reset (async, rst_n=0):
  - All ex_* outputs 0.
  - All registers in the register file 0.
  - fetch_stall combinationally 0 while in reset.
- Opcodes:
  - ADD 0x00, SUB 0x01, MUL 0x02: R-format; rs1/rs2 read, rf_we=1, imm=0.
  - LDB 0x10, LDW 0x11: M-format; rs1=base; imm=sext(instr[14:0]); rf_we=1.
  - STB 0x12, STW 0x13: M-format; dst field read as data into ex_rs2; rf_we=0.
  - MOV 0x14: M-format; imm=sext(instr[14:0]); rf_we=1.
  - BEQ 0x30: B-format; imm=sext({instr[24:20],instr[9:0]}); rs1=src1, rs2=src2; rf_we=0.
  - JUMP 0x31, IRET 0x33: B-format imm; rf_we=0.
  - TLBWRITE 0x32: rs1/rs2 read; rf_we=0.
- Register read: combinational from the RF, with write-through bypass. If wb_en and wb_addr matches a read index, the read returns wb_data the same cycle.
- RF write: on posedge when wb_en=1.
- Load-use hazard: hazard=1 when all of the following hold:
  - ex_valid=1;
  - ex_op is LDB or LDW;
  - valid_instr=1;
  - ex_dst equals a source index actually used by the incoming opcode.
- fetch_stall = hazard | ex_stall.
- EX register update at posedge, priority order:
  1. flush=1: ex_valid←0; incoming bundle dropped (flush wins over ex_stall and hazard).
  2. ex_stall=1: hold all ex_*.
  3. hazard=1: ex_valid←0 (bubble); other fields don't-care.
  4. Else: load the decoded bundle; ex_valid←valid_instr.
- Latency: one cycle from an accepted fetch bundle to ex_valid.
- A stalled instruction re-decodes next cycle and picks up any writeback value via the bypass.
- Reset asserted mid-stall or mid-flush: everything returns to reset values immediately; no pending state survives.

Optional Feature:
- Macro: CPU_DECODE_ILLEGAL_TRAP_EN.
- Enabled: an opcode outside the list is accepted with ex_valid=1, ex_illegal=1, rf_we=0, so execute can raise an exception.
- Disabled: ex_illegal is tied 0, and an unknown opcode becomes a bubble (ex_valid←0); fetch is not stalled.

Test Plan:
- Reset, then write r3=0x11 and r4=0x22 via wb; decode ADD dst=5, src1=3, src2=4 → next cycle ex_valid=1, ex_op=0x00, ex_rs1=0x11, ex_rs2=0x22, ex_rf_we=1.
- LDW dst=7 followed by SUB src1=7 → fetch_stall=1 for one cycle, one bubble (ex_valid=0); SUB is issued the following cycle.
- BEQ with offset_high=0x1F, offset_low=0x3FF → ex_imm=0xFFFFFFFF; offset_high=0x10, offset_low=0 → ex_imm=0xFFFFC000.
- Same-cycle wb_en to r9=0xABCD while decoding MOV/ADD that reads r9 → ex_rs1=0xABCD (bypass).
- flush and ex_stall both asserted with valid ADD in decode → ex_valid=0 next cycle; instruction dropped.
- Opcode 0x7F: with the macro defined → ex_valid=1, ex_illegal=1; without it → ex_valid=0.

Source files
------------

// File: rtl/cpu_decode_stage.sv
// Decode stage with a 32-entry register file, load-use hazard detection and the decode/execute
// pipeline register. Define CPU_DECODE_ILLEGAL_TRAP_EN to forward unknown opcodes flagged illegal.
module cpu_decode_stage #(
  parameter int unsigned VADDR_W = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NREGS   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_instr,
  input  logic [VADDR_W-1:0] next_PC,
  input  logic [31:0]        instr,
  output logic               fetch_stall,
  input  logic               ex_stall,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [4:0]         wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               ex_valid,
  output logic [VADDR_W-1:0] ex_pc,
  output logic [6:0]         ex_op,
  output logic [4:0]         ex_dst,
  output logic [DATA_W-1:0]  ex_rs1,
  output logic [DATA_W-1:0]  ex_rs2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic               ex_rf_we,
  output logic               ex_illegal
);

  localparam int unsigned EXT_W = DATA_W - 15;

  typedef enum logic [6:0] {
    OP_ADD      = 7'h00,
    OP_SUB      = 7'h01,
    OP_MUL      = 7'h02,
    OP_LDB      = 7'h10,
    OP_LDW      = 7'h11,
    OP_STB      = 7'h12,
    OP_STW      = 7'h13,
    OP_MOV      = 7'h14,
    OP_BEQ      = 7'h30,
    OP_JUMP     = 7'h31,
    OP_TLBWRITE = 7'h32,
    OP_IRET     = 7'h33
  } opcode_e;

  opcode_e           op;
  logic [4:0]        dst_idx;
  logic [4:0]        src1_idx;
  logic [4:0]        src2_idx;
  logic [4:0]        rs2_idx;
  logic [14:0]       m_off;
  logic [14:0]       b_off;
  logic [DATA_W-1:0] m_imm;
  logic [DATA_W-1:0] b_imm;

  logic              known;
  logic              dec_rf_we;
  logic              use_src1;
  logic              use_src2;
  logic              is_store;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_valid;

  logic [DATA_W-1:0] rf [NREGS];
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;

  logic              ex_is_load;
  logic              hazard;

  assign op       = opcode_e'(instr[31:25]);
  assign dst_idx  = instr[24:20];
  assign src1_idx = instr[19:15];
  assign src2_idx = instr[14:10];
  assign m_off    = instr[14:0];
  assign b_off    = {instr[24:20], instr[9:0]};
  assign m_imm    = {{EXT_W{m_off[14]}}, m_off};
  assign b_imm    = {{EXT_W{b_off[14]}}, b_off};

  always_comb begin
    known     = 1'b0;
    dec_rf_we = 1'b0;
    use_src1  = 1'b0;
    use_src2  = 1'b0;
    is_store  = 1'b0;
    dec_imm   = '0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL: begin
        known     = 1'b1;
        dec_rf_we = 1'b1;
        use_src1  = 1'b1;
        use_src2  = 1'b1;
      end
      OP_LDB, OP_LDW: begin
        known     = 1'b1;
        dec_rf_we = 1'b1;
        use_src1  = 1'b1;
        dec_imm   = m_imm;
      end
      OP_STB, OP_STW: begin
        known     = 1'b1;
        use_src1  = 1'b1;
        use_src2  = 1'b1;
        is_store  = 1'b1;
        dec_imm   = m_imm;
      end
      OP_MOV: begin
        known     = 1'b1;
        dec_rf_we = 1'b1;
        dec_imm   = m_imm;
      end
      OP_BEQ: begin
        known     = 1'b1;
        use_src1  = 1'b1;
        use_src2  = 1'b1;
        dec_imm   = b_imm;
      end
      OP_JUMP, OP_IRET: begin
        known     = 1'b1;
        dec_imm   = b_imm;
      end
      OP_TLBWRITE: begin
        known     = 1'b1;
        use_src1  = 1'b1;
        use_src2  = 1'b1;
      end
      default: ;
    endcase
  end

  // Stores route the dst field through the second read port as store data.
  assign rs2_idx = is_store ? dst_idx : src2_idx;

  assign rs1_val = (wb_en && (wb_addr == src1_idx)) ? wb_data : rf[src1_idx];
  assign rs2_val = (wb_en && (wb_addr == rs2_idx))  ? wb_data : rf[rs2_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf[i[4:0]] <= '0;
      end
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  assign ex_is_load = (ex_op == OP_LDB) || (ex_op == OP_LDW);

  assign hazard = ex_valid && ex_is_load && valid_instr &&
                  ((use_src1 && (ex_dst == src1_idx)) ||
                   (use_src2 && (ex_dst == rs2_idx)));

  // Gated by rst_n so fetch never sees a stall while the stage is held in reset.
  assign fetch_stall = rst_n & (hazard | ex_stall);

`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
  logic dec_illegal;

  assign dec_valid   = valid_instr;
  assign dec_illegal = valid_instr & ~known;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_illegal <= 1'b0;
    end else if (flush) begin
      ex_illegal <= 1'b0;
    end else if (!ex_stall) begin
      ex_illegal <= hazard ? 1'b0 : dec_illegal;
    end
  end
`else
  assign dec_valid  = valid_instr & known;
  assign ex_illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_op    <= '0;
      ex_dst   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_imm   <= '0;
      ex_rf_we <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_stall) begin
      ex_valid <= ex_valid;
    end else begin
      ex_valid <= dec_valid & ~hazard;
      ex_pc    <= next_PC;
      ex_op    <= instr[31:25];
      ex_dst   <= dst_idx;
      ex_rs1   <= rs1_val;
      ex_rs2   <= rs2_val;
      ex_imm   <= dec_imm;
      ex_rf_we <= dec_rf_we;
    end
  end

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Self-checking bench for cpu_decode_stage: directed cases plus randomized traffic
// compared against a per-cycle behavioural model of the decode stage.
module tb_cpu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_instr;
  logic [31:0] next_PC;
  logic [31:0] instr;
  logic        fetch_stall;
  logic        ex_stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [6:0]  ex_op;
  logic [4:0]  ex_dst;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_imm;
  logic        ex_rf_we;
  logic        ex_illegal;

  cpu_decode_stage #(.VADDR_W(32), .DATA_W(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_instr(valid_instr), .next_PC(next_PC),
    .instr(instr), .fetch_stall(fetch_stall), .ex_stall(ex_stall), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_op(ex_op), .ex_dst(ex_dst), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_imm(ex_imm), .ex_rf_we(ex_rf_we), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  dst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        we;
    logic        ill;
  } ex_t;

  ex_t         m;
  logic [31:0] mrf [32];

  // Instruction classes: R alu, L load, S store, V mov, B beq, J jump/iret, T tlbwrite, X unknown.
  function automatic byte fmt_of(input logic [6:0] op);
    case (op)
      7'h00, 7'h01, 7'h02: return "R";
      7'h10, 7'h11:        return "L";
      7'h12, 7'h13:        return "S";
      7'h14:               return "V";
      7'h30:               return "B";
      7'h31, 7'h33:        return "J";
      7'h32:               return "T";
      default:             return "X";
    endcase
  endfunction

  function automatic logic [31:0] sext15(input logic [14:0] x);
    return {{17{x[14]}}, x};
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [9:0] lo);
    return {op, d, s1, s2, lo};
  endfunction

  function automatic logic [31:0] rd(input logic [4:0] idx);
    return (wb_en && wb_addr == idx) ? wb_data : mrf[idx];
  endfunction

  task automatic model_reset();
    m = '0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
  endtask

  task automatic check_ex(input string where);
    check({where, ".ex_valid"}, ex_valid, m.v);
    if (m.v) begin
      check({where, ".ex_pc"},      ex_pc,      m.pc);
      check({where, ".ex_op"},      ex_op,      m.op);
      check({where, ".ex_dst"},     ex_dst,     m.dst);
      check({where, ".ex_rs1"},     ex_rs1,     m.rs1);
      check({where, ".ex_rs2"},     ex_rs2,     m.rs2);
      check({where, ".ex_imm"},     ex_imm,     m.imm);
      check({where, ".ex_rf_we"},   ex_rf_we,   m.we);
      check({where, ".ex_illegal"}, ex_illegal, m.ill);
    end
  endtask

  // One clock with the inputs currently driven; checks fetch_stall before the edge, EX after.
  task automatic step(input string where);
    byte         f;
    logic [4:0]  d, s1, s2;
    logic        u1, u2, ud, haz;
    logic [31:0] r1v, r2v, imm;
    f  = fmt_of(instr[31:25]);
    d  = instr[24:20];
    s1 = instr[19:15];
    s2 = instr[14:10];
    u1 = (f == "R") || (f == "L") || (f == "S") || (f == "B") || (f == "T");
    u2 = (f == "R") || (f == "B") || (f == "T");
    ud = (f == "S");
    haz = m.v && (m.op == 7'h10 || m.op == 7'h11) && valid_instr &&
          ((u1 && m.dst == s1) || (u2 && m.dst == s2) || (ud && m.dst == d));
    r1v = rd(s1);
    r2v = ud ? rd(d) : rd(s2);
    if (f == "L" || f == "S" || f == "V")      imm = sext15(instr[14:0]);
    else if (f == "B" || f == "J")             imm = sext15({instr[24:20], instr[9:0]});
    else                                       imm = '0;
    #1;
    check({where, ".fetch_stall"}, fetch_stall, haz || ex_stall);
    @(posedge clk);
    if (flush) begin
      m.v = 1'b0;
    end else if (ex_stall) begin
      m = m;
    end else if (haz) begin
      m.v = 1'b0;
    end else begin
      m.v   = valid_instr && (f != "X" || TRAP);
      m.ill = valid_instr && f == "X" && TRAP;
      m.pc  = next_PC;
      m.op  = instr[31:25];
      m.dst = d;
      m.rs1 = r1v;
      m.rs2 = r2v;
      m.imm = imm;
      m.we  = (f == "R") || (f == "L") || (f == "V");
    end
    if (wb_en) mrf[wb_addr] = wb_data;
    #1;
    check_ex(where);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    valid_instr = v;
    instr       = ins;
    next_PC     = $urandom;
    ex_stall    = st;
    flush       = fl;
    wb_en       = we;
    wb_addr     = wa;
    wb_data     = wd;
  endtask

  task automatic do_reset(input string where);
    rst_n = 1'b0;
    drive(1'b1, mk(7'h00, 5'd1, 5'd2, 5'd3, 10'd0), 1'b1, 1'b0, 1'b1, 5'd2, 32'h5A5A);
    #1;
    check({where, ".fetch_stall"}, fetch_stall, 1'b0);
    check({where, ".ex_valid"},    ex_valid,    1'b0);
    check({where, ".ex_fields"},   {ex_pc, ex_op, ex_dst, ex_rf_we, ex_illegal}, '0);
    check({where, ".ex_data"},     {ex_rs1, ex_rs2}, '0);
    check({where, ".ex_imm"},      ex_imm, '0);
    model_reset();
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 5'd0, '0);
    rst_n = 1'b1;
  endtask

  logic [6:0] op_tbl [13];

  initial begin
    op_tbl = '{7'h00, 7'h01, 7'h02, 7'h10, 7'h11, 7'h12, 7'h13,
               7'h14, 7'h30, 7'h31, 7'h32, 7'h33, 7'h7F};
    do_reset("reset");

    // register file reads back zero after reset
    drive(1'b1, mk(7'h00, 5'd1, 5'd3, 5'd4, 10'd0), 1'b0, 1'b0, 1'b0, 5'd0, '0);
    step("rf_zero");
    check("rf_zero.rs1", ex_rs1, 32'h0);

    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h11);  step("wb_r3");
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h22);  step("wb_r4");
    drive(1'b1, mk(7'h00, 5'd5, 5'd3, 5'd4, 10'd0), 1'b0, 1'b0, 1'b0, 5'd0, '0);
    step("add");
    check("add.valid", ex_valid, 1'b1);
    check("add.op",    ex_op,    7'h00);
    check("add.rs1",   ex_rs1,   32'h11);
    check("add.rs2",   ex_rs2,   32'h22);
    check("add.we",    ex_rf_we, 1'b1);

    // load-use: one bubble, then SUB issues
    drive(1'b1, mk(7'h11, 5'd7, 5'd1, 5'd0, 10'h4), 1'b0, 1'b0, 1'b0, 5'd0, '0);
    step("ldw");
    drive(1'b1, mk(7'h01, 5'd8, 5'd7, 5'd2, 10'd0), 1'b0, 1'b0, 1'b0, 5'd0, '0);
    #1;
    check("ldu.stall", fetch_stall, 1'b1);
    step("ldu_bubble");
    check("ldu.bubble", ex_valid, 1'b0);
    step("ldu_issue");
    check("ldu.issue_valid", ex_valid, 1'b1);
    check("ldu.issue_op",    ex_op,    7'h01);
    check("ldu.no_stall",    fetch_stall, 1'b0);

    drive(1'b1, mk(7'h30, 5'h1F, 5'd1, 5'd2, 10'h3FF), 1'b0, 1'b0, 1'b0, 5'd0, '0);
    step("beq_ones");
    check("beq_ones.imm", ex_imm, 32'hFFFF_FFFF);
    drive(1'b1, mk(7'h30, 5'h10, 5'd1, 5'd2, 10'h000), 1'b0, 1'b0, 1'b0, 5'd0, '0);
    step("beq_min");
    check("beq_min.imm", ex_imm, 32'hFFFF_C000);

    drive(1'b1, mk(7'h00, 5'd10, 5'd9, 5'd9, 10'd0), 1'b0, 1'b0, 1'b1, 5'd9, 32'hABCD);
    step("bypass");
    check("bypass.rs1", ex_rs1, 32'hABCD);
    check("bypass.rs2", ex_rs2, 32'hABCD);

    drive(1'b1, mk(7'h00, 5'd5, 5'd3, 5'd4, 10'd0), 1'b1, 1'b1, 1'b0, 5'd0, '0);
    step("flush_stall");
    check("flush_stall.valid", ex_valid, 1'b0);

    drive(1'b1, mk(7'h7F, 5'd1, 5'd2, 5'd3, 10'd0), 1'b0, 1'b0, 1'b0, 5'd0, '0);
    step("illegal");
    check("illegal.valid",   ex_valid,   TRAP);
    check("illegal.flag",    ex_illegal, TRAP);
    check("illegal.no_stall", fetch_stall, 1'b0);

    // reset while execute is stalled on a live bundle
    drive(1'b1, mk(7'h02, 5'd6, 5'd3, 5'd4, 10'd0), 1'b0, 1'b0, 1'b0, 5'd0, '0);
    step("pre_rst");
    drive(1'b1, mk(7'h02, 5'd6, 5'd3, 5'd4, 10'd0), 1'b1, 1'b0, 1'b0, 5'd0, '0);
    step("pre_rst_stall");
    do_reset("mid_reset");

    for (int n = 0; n < 3000; n++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : op_tbl[$urandom_range(0, 12)];
      drive($urandom_range(0, 9) != 0,
            mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 10'($urandom)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      step("rand");
      if (n % 1000 == 999) do_reset("rand_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
